impl_seq_checker: RTL and testbench

Synthesizable multi-channel checker for the implication "trig |-> a ##DELAY b", with overlapping or non-overlapping mode. It tracks every in-flight attempt in a per-channel shift pipeline, so overlapping attempts are all checked. Each attempt produces one-cycle pass/fail pulses, and the block keeps saturating pass/fail counters plus a sticky first-failure record. It instantiates alongside DUT interfaces as an on-chip or emulation-friendly replacement for simulation-only concurrent assertions.

---
 rtl/impl_seq_checker.sv | 119 +++++++++++
 tb/tb_impl_seq_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/impl_seq_checker.sv
// Synthesizable multi-channel checker for "trig |-> a ##DELAY b" (or |=> when OVERLAP=0).
// Every in-flight attempt rides a per-channel shift pipeline; results are one-cycle registered pulses.
module impl_seq_checker #(
  parameter  int NUM_CH  = 1,
  parameter  int DELAY   = 2,
  parameter  int OVERLAP = 1,
  parameter  int CNT_W   = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] a,
  input  logic [NUM_CH-1:0] b,
  output logic [NUM_CH-1:0] pass,
  output logic [NUM_CH-1:0] fail_a,
  output logic [NUM_CH-1:0] fail_b,
  output logic [NUM_CH-1:0] busy,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err,
  output logic [CH_W-1:0]   first_fail_ch
);

  localparam int SUM_W = CNT_W + $clog2(2 * NUM_CH + 1);

  function automatic logic [SUM_W-1:0] popcnt(input logic [NUM_CH-1:0] v);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s = s + SUM_W'(v[i]);
    end
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cur,
                                               input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(cur) + inc;
    return (s > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [NUM_CH-1:0] r_pipe [1:DELAY];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_pass, r_fail_a, r_fail_b, r_busy;
  logic [CNT_W-1:0]  r_pass_cnt, r_fail_cnt;
  logic              r_err;
  logic [CH_W-1:0]   r_first_ch;

  logic [NUM_CH-1:0] w_pend_nxt, w_asamp, w_stage1;
  logic [NUM_CH-1:0] w_pass_nxt, w_fa_nxt, w_fb_nxt, w_busy_nxt, w_fail_any;
  logic [CH_W-1:0]   w_first_ch;

  // Next-state decode: where a is sampled, what completes this edge, and the lowest failing channel.
  always_comb begin
    w_pend_nxt = (OVERLAP == 0) ? (trig & {NUM_CH{en}}) : {NUM_CH{1'b0}};
    w_asamp    = (OVERLAP != 0) ? (trig & {NUM_CH{en}}) : r_pend;
    w_fa_nxt   = w_asamp & ~a;
    w_stage1   = w_asamp & a;
    w_pass_nxt = r_pipe[DELAY] & b;
    w_fb_nxt   = r_pipe[DELAY] & ~b;
    // Stage i+1 after this edge holds today's stage i, so the last stage never counts toward busy.
    w_busy_nxt = w_stage1 | w_pend_nxt;
    for (int i = 1; i < DELAY; i++) begin
      w_busy_nxt = w_busy_nxt | r_pipe[i];
    end
    w_fail_any = w_fa_nxt | w_fb_nxt;
    w_first_ch = {CH_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_first_ch = w_fail_any[i] ? CH_W'(i) : w_first_ch;
    end
  end

  // Pipeline, result pulses, saturating counters and sticky first-failure record.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 1; i <= DELAY; i++) begin
        r_pipe[i] <= {NUM_CH{1'b0}};
      end
      r_pend     <= {NUM_CH{1'b0}};
      r_pass     <= {NUM_CH{1'b0}};
      r_fail_a   <= {NUM_CH{1'b0}};
      r_fail_b   <= {NUM_CH{1'b0}};
      r_busy     <= {NUM_CH{1'b0}};
      r_pass_cnt <= {CNT_W{1'b0}};
      r_fail_cnt <= {CNT_W{1'b0}};
      r_err      <= 1'b0;
      r_first_ch <= {CH_W{1'b0}};
    end else begin
      r_pipe[1] <= w_stage1;
      for (int i = 2; i <= DELAY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      r_pend     <= w_pend_nxt;
      r_pass     <= w_pass_nxt;
      r_fail_a   <= w_fa_nxt;
      r_fail_b   <= w_fb_nxt;
      r_busy     <= w_busy_nxt;
      r_pass_cnt <= sat_add(r_pass_cnt, popcnt(w_pass_nxt));
      r_fail_cnt <= sat_add(r_fail_cnt, popcnt(w_fa_nxt) + popcnt(w_fb_nxt));
      if (!r_err && (|w_fail_any)) begin
        r_err      <= 1'b1;
        r_first_ch <= w_first_ch;
      end
    end
  end

  assign pass          = r_pass;
  assign fail_a        = r_fail_a;
  assign fail_b        = r_fail_b;
  assign busy          = r_busy;
  assign pass_cnt      = r_pass_cnt;
  assign fail_cnt      = r_fail_cnt;
  assign err           = r_err;
  assign first_fail_ch = r_first_ch;

endmodule

// File: tb/tb_impl_seq_checker.sv
// Randomized bench: three checker configurations share one stimulus stream and are compared
// every cycle against an attempt-level model computed from the recorded input history.
module tb_impl_seq_checker;

  localparam int NCYC = 2000;
  localparam int NINST = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] trig = 4'd0, a = 4'd0, b = 4'd0;

  logic [3:0] pass0, fa0, fb0, busy0;
  logic [2:0] pc0, fc0;
  logic       err0;
  logic [1:0] ffc0;
  logic [1:0] pass1, fa1, fb1, busy1;
  logic [4:0] pc1, fc1;
  logic       err1;
  logic       ffc1;
  logic       pass2, fa2, fb2, busy2;
  logic [15:0] pc2, fc2;
  logic       err2;
  logic       ffc2;

  int n_checks = 0;
  int n_fail = 0;

  bit [3:0] h_trig [NCYC];
  bit [3:0] h_a    [NCYC];
  bit [3:0] h_b    [NCYC];
  bit       h_en   [NCYC];
  bit       h_kill [NCYC];

  longint m_pc  [NINST];
  longint m_fc  [NINST];
  bit     m_err [NINST];
  int     m_ffc [NINST];

  always #5 clk = ~clk;

  impl_seq_checker #(.NUM_CH(4), .DELAY(2), .OVERLAP(1), .CNT_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .a(a), .b(b),
    .pass(pass0), .fail_a(fa0), .fail_b(fb0), .busy(busy0), .pass_cnt(pc0), .fail_cnt(fc0),
    .err(err0), .first_fail_ch(ffc0));

  impl_seq_checker #(.NUM_CH(2), .DELAY(3), .OVERLAP(0), .CNT_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig[1:0]), .a(a[1:0]), .b(b[1:0]),
    .pass(pass1), .fail_a(fa1), .fail_b(fb1), .busy(busy1), .pass_cnt(pc1), .fail_cnt(fc1),
    .err(err1), .first_fail_ch(ffc1));

  impl_seq_checker #(.NUM_CH(1), .DELAY(1), .OVERLAP(1), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig[0:0]), .a(a[0:0]), .b(b[0:0]),
    .pass(pass2), .fail_a(fa2), .fail_b(fb2), .busy(busy2), .pass_cnt(pc2), .fail_cnt(fc2),
    .err(err2), .first_fail_ch(ffc2));

  function automatic int cfg_nch(input int i);
    case (i)
      0: return 4;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_dly(input int i);
    case (i)
      0: return 2;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_ov(input int i);
    case (i)
      1: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_cw(input int i);
    case (i)
      0: return 3;
      1: return 5;
      default: return 16;
    endcase
  endfunction

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit killed(input int lo, input int hi);
    for (int e = lo; e <= hi; e++) begin
      if (h_kill[e]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // An attempt that started at edge k on channel c and has survived up to edge n.
  function automatic bit alive(input int k, input int n, input int c);
    if (k < 0) return 1'b0;
    return h_en[k] && h_trig[k][c] && !killed(k, n);
  endfunction

  task automatic expect_edge(input int i, input int n,
                             output bit [3:0] ep, output bit [3:0] efa,
                             output bit [3:0] efb, output bit [3:0] ebusy);
    int off, d, ka;
    off = (cfg_ov(i) != 0) ? 0 : 1;
    d = cfg_dly(i);
    ep = '0; efa = '0; efb = '0; ebusy = '0;
    for (int c = 0; c < cfg_nch(i); c++) begin
      if (alive(n - off, n, c) && !h_a[n][c]) efa[c] = 1'b1;
      ka = n - d;
      if (ka >= 0 && alive(ka - off, n, c) && h_a[ka][c]) begin
        ep[c]  = h_b[n][c];
        efb[c] = !h_b[n][c];
      end
      for (int j = 0; j < d; j++) begin
        ka = n - j;
        if (ka >= 0 && alive(ka - off, n, c) && h_a[ka][c]) ebusy[c] = 1'b1;
      end
      if (off == 1 && alive(n, n, c)) ebusy[c] = 1'b1;
    end
  endtask

  task automatic model_and_check(input int n);
    bit [3:0] ep, efa, efb, ebusy;
    bit [3:0] op, ofa, ofb, obusy;
    longint opc, ofc, maxv;
    int oerr, offc, np, nf;
    for (int i = 0; i < NINST; i++) begin
      expect_edge(i, n, ep, efa, efb, ebusy);
      maxv = (longint'(1) << cfg_cw(i)) - 1;
      if (h_kill[n]) begin
        m_pc[i] = 0; m_fc[i] = 0; m_err[i] = 1'b0; m_ffc[i] = 0;
      end else begin
        np = 0; nf = 0;
        for (int c = 0; c < 4; c++) begin
          np += int'(ep[c]);
          nf += int'(efa[c]) + int'(efb[c]);
        end
        m_pc[i] = (m_pc[i] + np > maxv) ? maxv : m_pc[i] + np;
        m_fc[i] = (m_fc[i] + nf > maxv) ? maxv : m_fc[i] + nf;
        if (!m_err[i] && (efa | efb) != 4'd0) begin
          m_err[i] = 1'b1;
          for (int c = 3; c >= 0; c--) begin
            if (efa[c] | efb[c]) m_ffc[i] = c;
          end
        end
      end
      case (i)
        0: begin op = pass0; ofa = fa0; ofb = fb0; obusy = busy0;
                 opc = pc0; ofc = fc0; oerr = err0; offc = ffc0; end
        1: begin op = {2'b0, pass1}; ofa = {2'b0, fa1}; ofb = {2'b0, fb1}; obusy = {2'b0, busy1};
                 opc = pc1; ofc = fc1; oerr = err1; offc = ffc1; end
        default: begin op = {3'b0, pass2}; ofa = {3'b0, fa2}; ofb = {3'b0, fb2};
                 obusy = {3'b0, busy2}; opc = pc2; ofc = fc2; oerr = err2; offc = ffc2; end
      endcase
      check_eq($sformatf("d%0d.pass@%0d", i, n), op, ep);
      check_eq($sformatf("d%0d.fail_a@%0d", i, n), ofa, efa);
      check_eq($sformatf("d%0d.fail_b@%0d", i, n), ofb, efb);
      check_eq($sformatf("d%0d.busy@%0d", i, n), obusy, ebusy);
      check_eq($sformatf("d%0d.pass_cnt@%0d", i, n), opc, m_pc[i]);
      check_eq($sformatf("d%0d.fail_cnt@%0d", i, n), ofc, m_fc[i]);
      check_eq($sformatf("d%0d.err@%0d", i, n), oerr, int'(m_err[i]));
      check_eq($sformatf("d%0d.first_fail_ch@%0d", i, n), offc, m_ffc[i]);
    end
  endtask

  initial begin
    int mode;
    bit v_rst, v_clr;
    bit [3:0] v_a, v_b;
    for (int i = 0; i < NINST; i++) begin
      m_pc[i] = 0; m_fc[i] = 0; m_err[i] = 1'b0; m_ffc[i] = 0;
    end
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      // Modes: 0 mixed, 1 sparse enable, 2 dense passing traffic, 3 frequent clears.
      mode = (n / 250) % 4;
      v_rst = (n < 3) || ($urandom_range(0, 199) == 0);
      v_clr = (mode == 3) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 99) == 0);
      for (int c = 0; c < 4; c++) begin
        v_a[c] = (mode == 2) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0);
        v_b[c] = (mode == 2) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0);
      end
      rst_n = !v_rst;
      clr   = v_clr;
      en    = (mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) != 0);
      trig  = (mode == 2) ? 4'hF : 4'($urandom_range(0, 15));
      a     = v_a;
      b     = v_b;
      h_kill[n] = v_rst | v_clr;
      h_en[n]   = en;
      h_trig[n] = trig;
      h_a[n]    = a;
      h_b[n]    = b;
      @(posedge clk);
      #1;
      model_and_check(n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
